// File: rtl/seq_calculator_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_calculator_if
//  Description : Request/response bundle for the sequential calculator.
//                master drives a request (start, op, a, b); slave returns
//                status and the held result (busy, done, result, err, ovf).
//  Revision    : 1.0 - initial release
// ============================================================================
//  Signals
//    start   request strobe, only looked at while the calculator is idle
//    op      3-bit operation code
//    a, b    W-bit operands
//    busy    high while the calculator iterates
//    done    one-cycle pulse, result/err/ovf valid
//    result  2*W-bit result, held until the next completion
//    err     divide-by-zero or reserved op
//    ovf     power saturated
// ============================================================================
interface seq_calculator_if #(
  parameter int W = 8
) ();
  logic             start;
  logic [2:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   result;
  logic             err;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, err, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, err, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_calculator.sv
`default_nettype none
// ============================================================================
//  Module      : seq_calculator
//  Description : Multi-cycle calculator: add, sub, quotient, remainder,
//                multiply, integer square root and saturating power.
//                One request at a time; IDLE -> CALC -> DONE -> IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Ports
//    clk     sole clock, rising edge
//    rst_n   asynchronous active-low reset
//    bus     seq_calculator_if.slave (start/op/a/b in,
//            busy/done/result/err/ovf out)
// ============================================================================
module seq_calculator #(
  parameter int W  = 8,
  parameter int RW = 2 * W
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  seq_calculator_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_QUO = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_REM = 3'b100;
  localparam logic [2:0] OP_SQR = 3'b101;
  localparam logic [2:0] OP_POW = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    cnt_q, cnt_d;     // CALC cycles remaining
  logic [RW-1:0]   acc_q, acc_d;     // product / power accumulator
  logic [RW-1:0]   mcd_q, mcd_d;     // shifting multiplicand
  logic [W-1:0]    shr_q, shr_d;     // multiplier / dividend->quotient / radicand
  logic [W-1:0]    rem_q, rem_d;     // division or sqrt partial remainder
  logic [W-1:0]    root_q, root_d;   // sqrt partial root
  logic            pov_q, pov_d;     // power saturated during iteration
  logic [RW-1:0]   result_q, result_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;

  // --------------------------------------------------------------------------
  // One iteration step of every datapath; the FSM picks the one for op_q.
  // --------------------------------------------------------------------------
  // Shift-add multiply: add multiplicand when the current multiplier bit is 1.
  logic [RW-1:0] w_mul_acc;
  assign w_mul_acc = shr_q[0] ? (acc_q + mcd_q) : acc_q;

  // Restoring division: the dividend shifts out of shr_q MSB-first while the
  // quotient bits shift in at the bottom. The remainder always stays below b,
  // so W bits hold it once the trial subtraction is accepted.
  logic [W:0]    w_div_sh;
  logic          w_div_ge;
  logic [W-1:0]  w_div_rem;
  logic [W-1:0]  w_div_quo;
  assign w_div_sh  = {rem_q, shr_q[W-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, b_q});
  assign w_div_rem = w_div_ge ? (w_div_sh[W-1:0] - b_q) : w_div_sh[W-1:0];
  assign w_div_quo = {shr_q[W-2:0], w_div_ge};

  // Digit-by-digit sqrt: bring down two radicand bits, try (4*root + 1).
  // The compare runs at full width; the remainder itself never exceeds
  // 2*root, so its low W bits are exact.
  logic [W+1:0]  w_sq_sh;
  logic [W+1:0]  w_sq_trial;
  logic          w_sq_ge;
  logic [W-1:0]  w_sq_rem;
  logic [W-1:0]  w_sq_root;
  assign w_sq_sh    = {rem_q, shr_q[W-1:W-2]};
  assign w_sq_trial = {root_q, 2'b01};
  assign w_sq_ge    = (w_sq_sh >= w_sq_trial);
  assign w_sq_rem   = w_sq_ge ? (w_sq_sh[W-1:0] - w_sq_trial[W-1:0]) : w_sq_sh[W-1:0];
  assign w_sq_root  = {root_q[W-2:0], w_sq_ge};

  // Power: one full-width multiply per cycle; once saturated the accumulator
  // is frozen so the remaining iterations only burn the cycle count.
  logic [RW+W-1:0] w_pow_prod;
  logic [RW-1:0]   w_pow_acc;
  logic            w_pow_ovf;
  assign w_pow_prod = {{W{1'b0}}, acc_q} * {{RW{1'b0}}, a_q};
  always_comb begin
    w_pow_acc = acc_q;
    w_pow_ovf = pov_q;
    if (!pov_q) begin
      if (|w_pow_prod[RW+W-1:RW]) begin
        w_pow_acc = {RW{1'b1}};
        w_pow_ovf = 1'b1;
      end else begin
        w_pow_acc = w_pow_prod[RW-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcd_d    = mcd_q;
    shr_d    = shr_q;
    rem_d    = rem_q;
    root_d   = root_q;
    pov_d    = pov_q;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CALC;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = (bus.op == OP_POW) ? RW'(1) : '0;
          mcd_d   = {{W{1'b0}}, bus.a};
          shr_d   = (bus.op == OP_MUL) ? bus.b : bus.a;
          rem_d   = '0;
          root_d  = '0;
          pov_d   = 1'b0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          // Number of CALC cycles: latency minus the DONE edge.
          case (bus.op)
            OP_MUL:         cnt_d = W'(W);
            OP_QUO, OP_REM: cnt_d = (bus.b == '0) ? W'(1) : W'(W);
            OP_SQR:         cnt_d = W'(W / 2);
            OP_POW:         cnt_d = (bus.b == '0) ? W'(1) : bus.b;
            default:        cnt_d = W'(1);
          endcase
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - W'(1);
        case (op_q)
          OP_MUL: begin
            acc_d = w_mul_acc;
            mcd_d = {mcd_q[RW-2:0], 1'b0};
            shr_d = {1'b0, shr_q[W-1:1]};
          end
          OP_QUO, OP_REM: begin
            rem_d = w_div_rem;
            shr_d = w_div_quo;
          end
          OP_SQR: begin
            rem_d  = w_sq_rem;
            root_d = w_sq_root;
            shr_d  = {shr_q[W-3:0], 2'b00};
          end
          OP_POW: begin
            acc_d = w_pow_acc;
            pov_d = w_pow_ovf;
          end
          default: ;
        endcase

        if (cnt_q == W'(1)) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          case (op_q)
            OP_ADD: result_d = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
            OP_SUB: result_d = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
            OP_MUL: result_d = w_mul_acc;
            OP_QUO: begin
              result_d = (b_q == '0) ? {RW{1'b1}} : {{W{1'b0}}, w_div_quo};
              err_d    = (b_q == '0);
            end
            OP_REM: begin
              result_d = (b_q == '0) ? {{W{1'b0}}, a_q} : {{W{1'b0}}, w_div_rem};
              err_d    = (b_q == '0);
            end
            OP_SQR: result_d = {{W{1'b0}}, w_sq_root};
            OP_POW: begin
              result_d = (b_q == '0) ? RW'(1) : w_pow_acc;
              ovf_d    = (b_q != '0) && w_pow_ovf;
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcd_q    <= '0;
      shr_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      pov_q    <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcd_q    <= mcd_d;
      shr_q    <= shr_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      pov_q    <= pov_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_calculator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_calculator
//  Description : Directed, table-driven bench for seq_calculator (W=8) plus
//                reset-abort and start-held-high sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_calculator;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  seq_calculator_if #(.W(W)) bus ();

  seq_calculator #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
    logic        ovf;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one request, scramble the inputs right after accept, then follow
  // it to done: latency (accept edge counted as edge 1), busy length, outputs
  // and the single-cycle done pulse.
  task automatic run_op(input vec_t v, input string nm);
    int edges = 0;
    int busy_cnt = 0;
    bit got = 0;
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    while (!got && edges < 400) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        bus.start = 1'b0;
        bus.op    = ~v.op;
        bus.a     = ~v.a;
        bus.b     = v.b + 8'd3;
      end
      if (bus.done) got = 1;
      else if (bus.busy) busy_cnt++;
    end
    check({nm, " done_seen"}, 32'(got), 32'd1);
    check({nm, " latency"}, 32'(edges), 32'(v.lat));
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'(v.lat - 1));
    check({nm, " result"}, 32'(bus.result), 32'(v.res));
    check({nm, " err"}, 32'(bus.err), 32'(v.err));
    check({nm, " ovf"}, 32'(bus.ovf), 32'(v.ovf));
    @(posedge clk); #1;
    check({nm, " done_pulse"}, 32'(bus.done), 32'd0);
    check({nm, " result_hold"}, 32'(bus.result), 32'(v.res));
  endtask

  vec_t vecs[21];

  initial begin
    int ndone;
    int nacc;
    bit prev_busy;

    //        op      a     b    result  err   ovf  L
    vecs[0]  = '{3'b000, 8'd200, 8'd100, 16'd300,   1'b0, 1'b0, 2};
    vecs[1]  = '{3'b001, 8'd3,   8'd5,   16'd65534, 1'b0, 1'b0, 2};
    vecs[2]  = '{3'b011, 8'd15,  8'd15,  16'd225,   1'b0, 1'b0, 9};
    vecs[3]  = '{3'b011, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b0, 9};
    vecs[4]  = '{3'b010, 8'd200, 8'd7,   16'd28,    1'b0, 1'b0, 9};
    vecs[5]  = '{3'b100, 8'd200, 8'd7,   16'd4,     1'b0, 1'b0, 9};
    vecs[6]  = '{3'b010, 8'd9,   8'd0,   16'd65535, 1'b1, 1'b0, 2};
    vecs[7]  = '{3'b100, 8'd9,   8'd0,   16'd9,     1'b1, 1'b0, 2};
    vecs[8]  = '{3'b010, 8'd255, 8'd1,   16'd255,   1'b0, 1'b0, 9};
    vecs[9]  = '{3'b100, 8'd7,   8'd200, 16'd7,     1'b0, 1'b0, 9};
    vecs[10] = '{3'b101, 8'd200, 8'd0,   16'd14,    1'b0, 1'b0, 5};
    vecs[11] = '{3'b101, 8'd255, 8'd0,   16'd15,    1'b0, 1'b0, 5};
    vecs[12] = '{3'b101, 8'd0,   8'd0,   16'd0,     1'b0, 1'b0, 5};
    vecs[13] = '{3'b101, 8'd144, 8'd99,  16'd12,    1'b0, 1'b0, 5};
    vecs[14] = '{3'b111, 8'd5,   8'd6,   16'd0,     1'b1, 1'b0, 2};
    vecs[15] = '{3'b110, 8'd2,   8'd16,  16'd65535, 1'b0, 1'b1, 17};
    vecs[16] = '{3'b110, 8'd7,   8'd0,   16'd1,     1'b0, 1'b0, 2};
    vecs[17] = '{3'b110, 8'd0,   8'd3,   16'd0,     1'b0, 1'b0, 4};
    vecs[18] = '{3'b110, 8'd2,   8'd15,  16'd32768, 1'b0, 1'b0, 16};
    vecs[19] = '{3'b110, 8'd16,  8'd4,   16'd65535, 1'b0, 1'b1, 5};
    vecs[20] = '{3'b110, 8'd3,   8'd5,   16'd243,   1'b0, 1'b0, 6};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 8'd0;
    bus.b     = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   32'(bus.busy),   32'd0);
    check("reset done",   32'(bus.done),   32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset err",    32'(bus.err),    32'd0);
    check("reset ovf",    32'(bus.ovf),    32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort: multiply, asynchronous reset pulse after edge 4, no done after.
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 8'd15; bus.b = 8'd15;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",   32'(bus.busy),   32'd0);
    check("abort done",   32'(bus.done),   32'd0);
    check("abort result", 32'(bus.result), 32'd0);
    check("abort err",    32'(bus.err),    32'd0);
    check("abort ovf",    32'(bus.ovf),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    run_op(vecs[0], "post_abort_add");

    // start held high for 30 edges on a multiply: accepts at edges 1, 11, 21,
    // done at 9, 19, 29.
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 8'd15; bus.b = 8'd15;
    ndone = 0;
    nacc = 0;
    prev_busy = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (bus.busy && !prev_busy) nacc++;
      prev_busy = bus.busy;
      if (bus.done) begin
        ndone++;
        check($sformatf("held_start result@%0d", i), 32'(bus.result), 32'd225);
        check($sformatf("held_start done_edge@%0d", i), 32'(i % 10), 32'd9);
      end
      if (i == 30) bus.start = 1'b0;
    end
    check("held_start accepts", 32'(nacc), 32'd3);
    check("held_start dones",   32'(ndone), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
